// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory port arbiter.
//   arb_state_e : arbiter FSM states
//   GNT_*       : encodings of the 2-bit grant output
//   cnt_width() : width of a counter able to hold 0..limit
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusyIf,
        StBusyDm,
        StDone
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_DM   = 2'b10;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: counts consecutive data grants made while fetch is waiting and
// flags when the count has reached STARVE_LIMIT. Saturates at the limit.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : one data grant was made while fetch was requesting
//   clr        : clear the count (takes priority over inc)
//   at_limit   : count equals STARVE_LIMIT
module arb_starve_counter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    import mem_arb_pkg::*;

    localparam int unsigned CntW = cnt_width(STARVE_LIMIT);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == Limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences one shared memory port between instruction fetch (IF) and
// load/store (MEM). A granted request is registered onto mem_*, held until mem_ack, and
// completed with a one-cycle ready pulse plus read data. Data requests win over fetch.
//   if_req/if_addr -> if_rdata/if_ready           fetch handshake
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_ready   load/store handshake
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ack memory port
//   grant (00 none, 01 fetch, 10 data), busy (not idle)
// All outputs are registered.
// Build option: define MEM_ARB_STARVE_GUARD_EN to grant fetch after STARVE_LIMIT
// consecutive data grants taken while fetch was waiting.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        grant,
    output logic              busy
);
    import mem_arb_pkg::*;

    arb_state_e        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              busy_q;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;

    // Arbitration outcome, only acted on in StIdle.
    logic fetch_boost;
    logic take_dm;
    logic take_if;

    assign take_dm = dm_req && !(if_req && fetch_boost);
    assign take_if = if_req && !take_dm;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic idle;
    logic cnt_inc;
    logic cnt_clr;

    assign idle    = (state_q == StIdle);
    assign cnt_inc = idle && take_dm && if_req;
    assign cnt_clr = idle && (take_if || !if_req);

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_counter (
        .clk     (clk),
        .reset   (reset),
        .inc     (cnt_inc),
        .clr     (cnt_clr),
        .at_limit(fetch_boost)
    );
`else
    logic unused_starve_limit;

    assign fetch_boost         = 1'b0;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (take_dm) begin
                    state_d     = StBusyDm;
                    grant_d     = GNT_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (take_if) begin
                    state_d    = StBusyIf;
                    grant_d    = GNT_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            StBusyIf: begin
                if (mem_ack) begin
                    state_d    = StDone;
                    if_rdata_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_ready_d = 1'b1;
                end
            end
            StBusyDm: begin
                if (mem_ack) begin
                    state_d = StDone;
                    // Stores leave the previous load data visible.
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_ready_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                grant_d = GNT_NONE;
            end
            default: begin
                state_d = StIdle;
                grant_d = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            grant_q     <= GNT_NONE;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            busy_q      <= (state_d != StIdle);
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the shared memory port.
module tb_mem_port_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int          LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_IF   = 2'b01;
    localparam logic [1:0] G_DM   = 2'b10;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [1:0]    grant;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .grant    (grant),
        .busy     (busy)
    );

    // Control outputs packed as {mem_req, mem_we, grant[1:0], busy, if_ready, dm_ready}.
    function automatic logic [6:0] ctl();
        return {mem_req, mem_we, grant, busy, if_ready, dm_ready};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) step();
        n_tests++;
        if (ctl() !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want %b", ctl(), 7'b0);
        end
        n_tests++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata});
        end
        n_tests++;
        if ({if_rdata, dm_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0", {if_rdata, dm_rdata});
        end
        reset = 1'b0;
        step();
        n_tests++;
        if (ctl() !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", ctl(), 7'b0);
        end
    endtask

    task automatic test_fetch_zero_wait();
        if_req  = 1'b1;
        if_addr = 32'h10;
        step();
        n_tests++;
        if (ctl() !== 7'b1_0_01_1_0_0 || mem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL fetch_c1: got ctl %b addr %h want %b addr 10", ctl(), mem_addr,
                     7'b1_0_01_1_0_0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h8C22_0004;
        step();
        n_tests++;
        if (ctl() !== 7'b0_0_01_1_1_0 || if_rdata !== 32'h8C22_0004) begin
            n_fail++;
            $display("FAIL fetch_c2: got ctl %b data %h want %b data 8c220004", ctl(), if_rdata,
                     7'b0_0_01_1_1_0);
        end
        if_req    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        step();
        n_tests++;
        if (ctl() !== 7'b0) begin
            n_fail++;
            $display("FAIL fetch_c3: got %b want %b", ctl(), 7'b0);
        end
    endtask

    task automatic test_simultaneous();
        if_req  = 1'b1;
        if_addr = 32'h20;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h40;
        step();
        n_tests++;
        if (ctl() !== 7'b1_0_10_1_0_0 || mem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL simul_c1: got ctl %b addr %h want %b addr 40", ctl(), mem_addr,
                     7'b1_0_10_1_0_0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        step();
        n_tests++;
        if (ctl() !== 7'b0_0_10_1_0_1 || dm_rdata !== 32'h1111_2222) begin
            n_fail++;
            $display("FAIL simul_c2: got ctl %b data %h want %b data 11112222", ctl(), dm_rdata,
                     7'b0_0_10_1_0_1);
        end
        dm_req  = 1'b0;
        mem_ack = 1'b0;
        step();
        n_tests++;
        if (ctl() !== 7'b0) begin
            n_fail++;
            $display("FAIL simul_c3: got %b want %b", ctl(), 7'b0);
        end
        step();
        n_tests++;
        if (ctl() !== 7'b1_0_01_1_0_0 || mem_addr !== 32'h20) begin
            n_fail++;
            $display("FAIL simul_c4: got ctl %b addr %h want %b addr 20", ctl(), mem_addr,
                     7'b1_0_01_1_0_0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h3333_4444;
        step();
        n_tests++;
        if (ctl() !== 7'b0_0_01_1_1_0 || if_rdata !== 32'h3333_4444) begin
            n_fail++;
            $display("FAIL simul_c5: got ctl %b data %h want %b data 33334444", ctl(), if_rdata,
                     7'b0_0_01_1_1_0);
        end
        if_req  = 1'b0;
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_store_wait();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h44;
        dm_wdata = 32'hDEAD_BEEF;
        step();
        for (int k = 1; k <= 4; k++) begin
            n_tests++;
            if (ctl() !== 7'b1_1_10_1_0_0 || mem_addr !== 32'h44 || mem_wdata !== 32'hDEAD_BEEF)
            begin
                n_fail++;
                $display("FAIL store_hold_c%0d: got ctl %b addr %h wdata %h want %b 44 deadbeef",
                         k, ctl(), mem_addr, mem_wdata, 7'b1_1_10_1_0_0);
            end
            mem_ack   = (k == 4);
            mem_rdata = 32'hBAD0_BAD0;
            step();
        end
        n_tests++;
        if (ctl() !== 7'b0_0_10_1_0_1 || dm_rdata !== 32'h1111_2222) begin
            n_fail++;
            $display("FAIL store_done: got ctl %b data %h want %b data 11112222", ctl(), dm_rdata,
                     7'b0_0_10_1_0_1);
        end
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_busy();
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h48;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (ctl() !== 7'b0 || mem_addr !== 32'h0 || dm_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async: got ctl %b addr %h data %h want 0", ctl(), mem_addr,
                     dm_rdata);
        end
        step();
        reset  = 1'b0;
        dm_req = 1'b0;
        step();
        n_tests++;
        if (ctl() !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", ctl(), 7'b0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        step();
        step();
        n_tests++;
        if (ctl() !== 7'b0 || dm_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL late_ack: got ctl %b data %h want 0", ctl(), dm_rdata);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_starvation();
        int         run    = 0;
        int         ngr    = 0;
        int         exp_if = 0;
        int         obs_if = 0;
        logic       prev   = 1'b0;
        logic [1:0] eg;
        if_req  = 1'b1;
        if_addr = 32'h80;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h84;
        for (int c = 0; c < 30; c++) begin
            step();
            if (mem_req && !prev) begin
                eg  = (GUARD && run == LIMIT) ? G_IF : G_DM;
                run = (eg == G_DM) ? ((run < LIMIT) ? run + 1 : run) : 0;
                ngr++;
                exp_if += (eg == G_IF) ? 1 : 0;
                obs_if += (grant == G_IF) ? 1 : 0;
                n_tests++;
                if (grant !== eg) begin
                    n_fail++;
                    $display("FAIL starve_grant_%0d: got %b want %b", ngr, grant, eg);
                end
            end
            prev      = mem_req;
            mem_ack   = mem_req;
            mem_rdata = $urandom;
        end
        n_tests++;
        if (ngr !== 10 || obs_if !== exp_if) begin
            n_fail++;
            $display("FAIL starve_totals: got %0d grants %0d fetch want 10 grants %0d fetch",
                     ngr, obs_if, exp_if);
        end
        drive_idle();
        repeat (4) step();
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [16];
        logic [31:0] bmem [16];
        bit          if_pend = 1'b0;
        bit          dm_pend = 1'b0;
        bit          dm_st   = 1'b0;
        logic [31:0] if_a    = '0;
        logic [31:0] dm_a    = '0;
        logic [31:0] dm_d    = '0;
        logic [31:0] exp_dm  = '0;
        logic [31:0] exp_a;
        logic [31:0] got;
        logic [31:0] want;
        bit          m_act   = 1'b0;
        int          m_own   = 0;
        int          m_gnt   = 0;
        int          m_rdy   = -1;
        int          m_free  = 0;
        int          run     = 0;
        int          wait_left = 0;
        int          own;
        bit          in_gnt;
        bit          in_req;
        logic [1:0]  eg;
        logic [6:0]  exp_ctl;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            bmem[i]    = ref_mem[i];
        end
        reset = 1'b1;
        drive_idle();
        step();
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            step();
            in_gnt  = m_act && (c >= m_gnt);
            in_req  = in_gnt && (m_rdy < 0 || c < m_rdy);
            eg      = in_gnt ? ((m_own == 1) ? G_DM : G_IF) : G_NONE;
            exp_ctl = {in_req, in_req && m_own == 1 && dm_st, eg, in_gnt,
                       m_act && m_rdy == c && m_own == 0, m_act && m_rdy == c && m_own == 1};
            n_tests++;
            if (ctl() !== exp_ctl) begin
                n_fail++;
                $display("FAIL rand_ctl_c%0d: got %b want %b", c, ctl(), exp_ctl);
            end
            if (in_req) begin
                exp_a = (m_own == 1) ? dm_a : if_a;
                n_tests++;
                if (mem_addr !== exp_a || (m_own == 1 && dm_st && mem_wdata !== dm_d)) begin
                    n_fail++;
                    $display("FAIL rand_bus_c%0d: got addr %h wdata %h want addr %h wdata %h",
                             c, mem_addr, mem_wdata, exp_a, dm_d);
                end
            end
            if (m_act && m_rdy == c) begin
                if (m_own == 0) begin
                    got     = if_rdata;
                    want    = ref_mem[if_a[5:2]];
                    if_pend = 1'b0;
                end else begin
                    if (dm_st) begin
                        ref_mem[dm_a[5:2]] = dm_d;
                    end else begin
                        exp_dm = ref_mem[dm_a[5:2]];
                    end
                    got     = dm_rdata;
                    want    = exp_dm;
                    dm_pend = 1'b0;
                end
                n_tests++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL rand_rdata_c%0d: port %0d got %h want %h", c, m_own, got, want);
                end
                m_act  = 1'b0;
                m_free = c + 1;
            end
            // Memory responder: random wait states, spurious acks while no access is open.
            if (in_req && m_rdy < 0) begin
                if (c == m_gnt) wait_left = $urandom_range(0, 3);
                if (wait_left == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = bmem[mem_addr[5:2]];
                    if (mem_we) bmem[mem_addr[5:2]] = mem_wdata;
                    m_rdy     = c + 1;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    wait_left--;
                end
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1;
                if_a    = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend = 1'b1;
                dm_st   = 1'($urandom_range(0, 1));
                dm_a    = $urandom & 32'hFFFF_FFFC;
                dm_d    = $urandom;
            end
            if_req   = if_pend;
            if_addr  = if_pend ? if_a : $urandom;
            dm_req   = dm_pend;
            dm_we    = dm_pend ? dm_st : 1'($urandom_range(0, 1));
            dm_addr  = dm_pend ? dm_a : $urandom;
            dm_wdata = dm_pend ? dm_d : $urandom;
            // Port free: data first unless fetch has waited through LIMIT data grants.
            if (!m_act && c >= m_free) begin
                if (if_pend && dm_pend && GUARD && run == LIMIT) own = 0;
                else if (dm_pend) own = 1;
                else if (if_pend) own = 0;
                else own = -1;
                if (!if_pend) run = 0;
                else if (own == 1) run = (run < LIMIT) ? run + 1 : run;
                else run = 0;
                if (own >= 0) begin
                    m_act = 1'b1;
                    m_own = own;
                    m_gnt = c + 1;
                    m_rdy = -1;
                end
            end
        end
        drive_idle();
        repeat (8) step();
    endtask

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_simultaneous();
        test_store_wait();
        test_reset_mid_busy();
        test_starvation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single shared memory port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline, enabling a unified instruction/data memory. Each requester gets a request/ready handshake; the arbiter registers the selected request, drives the memory port until acknowledged, then returns read data with a one-cycle ready pulse. The pipeline stalls IF/ID and PC while the corresponding ready is outstanding.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (used only with MEM_ARB_STARVE_GUARD_EN)

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid when if_ready
- if_ready  out  1  one-cycle completion pulse to IF
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address (ALU result)
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid when dm_ready
- dm_ready  out  1  one-cycle completion pulse to MEM
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, sampled with mem_ack
- mem_ack  in  1  memory completion; may be high in the first mem_req cycle (zero wait)
- grant  out  2  00 none, 01 fetch, 10 data (current owner)
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE: dm_req wins over if_req (older instruction first). On grant, latch address/we/wdata into mem_* registers, set mem_req=1, grant, go BUSY_x. No request: stay IDLE.
- BUSY_x: hold mem_* stable. On mem_ack=1: capture mem_rdata into x_rdata (loads and fetches only; stores leave dm_rdata unchanged), clear mem_req/mem_we, pulse x_ready, go DONE.
- DONE: x_ready high exactly this cycle; no grant issued; requester must drop or replace its request by the next edge. Next state IDLE, grant -> 00.
- Reset (any time, including mid-BUSY): state IDLE; mem_req, mem_we, if_ready, dm_ready = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; grant = 00; busy = 0. Abandoned memory transactions are not resumed.
- Requests arriving during BUSY/DONE wait; they are evaluated in IDLE.
- mem_ack outside BUSY_x is ignored.

## Timing
- Zero-wait memory: req sampled cycle 0 -> mem_req cycle 1 (ack cycle 1) -> ready cycle 2 -> IDLE cycle 3. Req-to-ready latency 2 cycles; one access per 3 cycles.
- N wait states: ready at cycle 2+N.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: counter of consecutive data grants made while if_req high; when it equals STARVE_LIMIT and both request in IDLE, fetch is granted. Counter clears on fetch grant, when if_req low in IDLE, and on reset; saturates at STARVE_LIMIT.
- Undefined: strict data-over-fetch priority; no counter logic.

## Structure
- Package mem_arb_pkg: FSM state enum, grant encodings (GNT_NONE, GNT_IF, GNT_DM).
- Sub-module arb_starve_counter (counter + limit compare), instantiated only under MEM_ARB_STARVE_GUARD_EN.

## Test plan
- Fetch only, zero wait: if_req, if_addr=0x10, mem_rdata=0x8C220004 with ack in cycle 1 -> mem_addr=0x10 cycle 1, if_ready and if_rdata=0x8C220004 cycle 2, grant=01 cycles 1-2.
- Simultaneous: if_req and dm_req (load 0x40) cycle 0 -> data served first (grant=10), dm_ready cycle 2, fetch granted cycle 4, if_ready cycle 5.
- Store with 3 wait states: dm_we=1, dm_addr=0x44, dm_wdata=0xDEADBEEF -> mem_we/mem_wdata held cycles 1-4, dm_ready cycle 5, dm_rdata unchanged.
- Reset asserted cycle 2 of BUSY_DM -> mem_req, dm_ready, busy, grant all 0 immediately; IDLE after deassert; later ack ignored.
- With MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, dm_req and if_req held continuously -> grants 10,10,10,10,01, then counter clear.
- Without macro, same stimulus -> fetch never granted while dm_req stays high.
